// File: rtl/psu_pkg.sv
// psu_pkg: shared state encoding and default widths for the pulse stretcher
package psu_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int MISS_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_e;
endpackage

// File: rtl/pulse_cnt.sv
// pulse_cnt: loadable down-counter shared by the HIGH and GAP phases, done while at 1
module pulse_cnt
  import psu_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins; otherwise count down and rest at zero
  always_comb cnt_d = load_i ? value_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  // counter register
  always_ff @(posedge clk)
    if (!n_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign done_o = cnt_q == W'(1);
endmodule

// File: rtl/pulse_stretch.sv
// pulse_stretch: stretches trigger pulses to a programmed width followed by a holdoff gap
module pulse_stretch
  import psu_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              trig,
  input  logic [CNT_W-1:0]  width,
  input  logic [CNT_W-1:0]  gap,
  input  logic              retrig,
  output logic              sig_out,
  output logic              busy,
  output logic              miss,
  output logic [MISS_W-1:0] miss_cnt
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   gap_q, gap_d, load_val;
  logic               load, done;
  logic               sig_q, sig_d, busy_q, busy_d, miss_q, miss_d;
  logic [MISS_W-1:0]  miss_cnt_q, miss_cnt_d;

  pulse_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .n_rst  (n_rst),
    .load_i (load),
    .value_i(load_val),
    .done_o (done)
  );

  // next state, counter loads and rejected-trigger detection; outputs follow the next state
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    load     = 1'b0;
    load_val = width;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: if (trig && width != '0) begin
        state_d = HIGH;
        gap_d   = gap;
        load    = 1'b1;
      end
      HIGH: if (trig && retrig && width != '0) begin
        gap_d = gap;
        load  = 1'b1;
      end else begin
        miss_d = trig;
        if (done) begin
          state_d  = gap_q != '0 ? GAP : IDLE;
          load     = gap_q != '0;
          load_val = gap_q;
        end
      end
      GAP: begin
        miss_d = trig;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    sig_d      = state_d == HIGH;
    busy_d     = state_d != IDLE;
    miss_cnt_d = (miss_d && miss_cnt_q != '1) ? miss_cnt_q + MISS_W'(1) : miss_cnt_q;
  end

  // state, latched gap and all registered outputs
  always_ff @(posedge clk)
    if (!n_rst) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      sig_q      <= 1'b0;
      busy_q     <= 1'b0;
      miss_q     <= 1'b0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      sig_q      <= sig_d;
      busy_q     <= busy_d;
      miss_q     <= miss_d;
      miss_cnt_q <= miss_cnt_d;
    end

  assign sig_out  = sig_q;
  assign busy     = busy_q;
  assign miss     = miss_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the width/gap counters.
REQ-002 Parameter MISS_W, default 8, SHALL set the width of the missed-trigger counter.
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 n_rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 trig  input  1  SHALL be the trigger request, sampled every rising edge, already synchronous to clk (typically a one-cycle edge pulse).
REQ-006 width  input  CNT_W  SHALL give the output high time in clk cycles.
REQ-007 gap  input  CNT_W  SHALL give the forced low (holdoff) time in cycles after each high time.
REQ-008 retrig  input  1  SHALL select the retrigger policy: 1 = extend the high time, 0 = ignore triggers while high.
REQ-009 sig_out  output  1  SHALL be the stretched pulse, registered.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE, registered.
REQ-011 miss  output  1  SHALL be a one-cycle pulse for each rejected trigger, registered.
REQ-012 miss_cnt  output  MISS_W  SHALL count rejected triggers, saturating at all-ones.

Function
REQ-013 The FSM SHALL have three states: IDLE, HIGH, GAP.
REQ-014 IDLE with trig=1 and width!=0: latch width and gap, go to HIGH; sig_out rises at the same edge (1-cycle latency from trig sampled).
REQ-015 IDLE with trig=1 and width=0: stay in IDLE, sig_out stays low, no miss.
REQ-016 HIGH: sig_out SHALL remain high for exactly the latched width cycles, then leave HIGH.
REQ-017 At the end of HIGH: go to GAP if latched gap!=0, else go to IDLE.
REQ-018 GAP: sig_out low for exactly the latched gap cycles, then go to IDLE.
REQ-019 HIGH with trig=1 and retrig=1: reload the counter with the current width input; sig_out stays high for width cycles counted from the edge after that trig; no miss.
REQ-020 Retrigger with width=0 on the input SHALL be treated as rejected (miss).
REQ-021 HIGH with trig=1 and retrig=0: the trigger SHALL be ignored and miss SHALL assert for one cycle.
REQ-022 GAP with trig=1: the trigger SHALL be ignored and miss SHALL assert, regardless of retrig.
REQ-023 trig on the last HIGH cycle SHALL follow REQ-019/REQ-021; trig on the last GAP cycle is rejected.
REQ-024 The first IDLE cycle after GAP or HIGH SHALL accept a trigger, giving a minimum period of width+gap+1 cycles.
REQ-025 miss_cnt SHALL increment by 1 on each miss pulse and hold at 2^MISS_W-1.
REQ-026 width and gap changes SHALL take effect only at acceptance or retrigger, never mid-count.
REQ-027 Held-high trig SHALL be treated as a request on every cycle; it is not edge-detected internally.

Reset
REQ-028 n_rst=0 at a rising edge SHALL force state IDLE, sig_out=0, busy=0, miss=0, miss_cnt=0, and clear the counter and latched width/gap.
REQ-029 Reset asserted mid-HIGH or mid-GAP SHALL drop sig_out at that same edge with no residual pulse after release.
REQ-030 A trigger present in the first cycle after reset release SHALL be accepted.

Structure
REQ-031 The state enumeration and the CNT_W/MISS_W defaults SHALL live in the shared package psu_pkg.
REQ-032 One sub-module, pulse_cnt, SHALL provide the loadable down-counter (load, value, done when at 1) and be reused for the HIGH and GAP phases.
REQ-033 All outputs SHALL be driven directly from flops with no combinational path from trig.

Verification
REQ-034 width=5, gap=3, single trig pulse -> sig_out high 5 cycles starting 1 edge after trig, busy high 8 cycles, miss never.
REQ-035 width=4, gap=0, retrig=1, trig at cycle 0 and again at cycle 2 -> sig_out continuous high 6 cycles, no miss.
REQ-036 width=4, gap=2, retrig=0, trig at cycles 0, 2, 5 -> one 4-cycle pulse, miss at 2 and 5, miss_cnt=2.
REQ-037 width=0, trig -> sig_out, busy, and miss all stay 0.
REQ-038 MISS_W=2, 5 rejected triggers -> miss_cnt saturates at 3.
REQ-039 width=10, reset low at cycle 4 of HIGH -> sig_out=0 at that edge; after release with no trig, sig_out stays 0.
